// File: rtl/gpio_edge_pkg.sv
// gpio_edge_pkg: shared edge-mode encoding and parameter limits for gpio_edge_irq
package gpio_edge_pkg;
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;
  localparam int MAX_CH = 32;
endpackage

// File: rtl/gpio_edge_irq_if.sv
// gpio_edge_irq_if: pad and register-file signals of gpio_edge_irq
// signal_in/mode/debounce_cycles/irq_en/clear flow into the block; level/edge_pulse/status/irq flow out
interface gpio_edge_irq_if #(
  parameter int NUM_CH     = 8,
  parameter int DEBOUNCE_W = 8
);
  logic [NUM_CH-1:0]     signal_in;
  logic [2*NUM_CH-1:0]   mode;
  logic [DEBOUNCE_W-1:0] debounce_cycles;
  logic [NUM_CH-1:0]     irq_en;
  logic [NUM_CH-1:0]     clear;
  logic [NUM_CH-1:0]     level;
  logic [NUM_CH-1:0]     edge_pulse;
  logic [NUM_CH-1:0]     status;
  logic                  irq;
  modport master (
    output signal_in, mode, debounce_cycles, irq_en, clear,
    input  level, edge_pulse, status, irq
  );
  modport slave (
    input  signal_in, mode, debounce_cycles, irq_en, clear,
    output level, edge_pulse, status, irq
  );
endinterface

// File: rtl/gpio_edge_chan.sv
// gpio_edge_chan: one channel - synchroniser, debounce counter, level flop, qualified edge pulse
// in: clk, rst (async active-low), signal_in, mode, debounce_cycles; out: level, edge_pulse, pulse_next
module gpio_edge_chan import gpio_edge_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_in,
  input  logic [1:0]            mode,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles,
  output logic                  level,
  output logic                  edge_pulse,
  output logic                  pulse_next
);
  logic [SYNC_STAGES-1:0] sync;
  logic [DEBOUNCE_W-1:0]  cnt;
  logic                   synced, update, rise_en, fall_en;
  edge_mode_t             m;
  assign m       = edge_mode_t'(mode);
  assign rise_en = m == EDGE_RISE || m == EDGE_BOTH;
  assign fall_en = m == EDGE_FALL || m == EDGE_BOTH;
  assign synced  = sync[SYNC_STAGES-1];
  // D-1 only matters when D != 0, so the underflow at D == 0 is harmless
  assign update  = synced != level && (debounce_cycles == '0 || cnt >= debounce_cycles - 1'b1);
  // level still holds its old value here, so it tells rising from falling
  assign pulse_next = update && ((!level && rise_en) || (level && fall_en));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= '0;
      level      <= 1'b0;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], signal_in};
      level      <= update ? synced : level;
      cnt        <= (synced == level || update) ? '0 : (&cnt ? cnt : cnt + 1'b1);
      edge_pulse <= pulse_next;
    end
  end
endmodule

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: NUM_CH debounced GPIO edge detectors with sticky W1C status and maskable irq
// in: clk, rst (async active-low); bus: slave side of gpio_edge_irq_if
module gpio_edge_irq import gpio_edge_pkg::*; #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input logic           clk,
  input logic           rst,
  gpio_edge_irq_if.slave bus
);
  logic [NUM_CH-1:0] level, edge_pulse, pulse_next, status;
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("NUM_CH must be in 1..%0d", MAX_CH);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .signal_in      (bus.signal_in[i]),
      .mode           (bus.mode[2*i+:2]),
      .debounce_cycles(bus.debounce_cycles),
      .level          (level[i]),
      .edge_pulse     (edge_pulse[i]),
      .pulse_next     (pulse_next[i])
    );
  end
  // a new edge wins over a coincident clear so no event is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status <= '0;
    else      status <= (status & ~bus.clear) | pulse_next;
  end
  assign bus.level      = level;
  assign bus.edge_pulse = edge_pulse;
  assign bus.status     = status;
  assign bus.irq        = |(status & bus.irq_en);
endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb_gpio_edge_irq: directed self-checking bench for gpio_edge_irq
module tb_gpio_edge_irq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   p1, p2, p;
  gpio_edge_irq_if #(.NUM_CH(8), .DEBOUNCE_W(8)) bus ();
  gpio_edge_irq #(.NUM_CH(8), .SYNC_STAGES(2), .DEBOUNCE_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_mode(input int ch, input logic [1:0] m);
    bus.mode[2*ch+:2] = m;
  endtask
  initial begin
    bus.signal_in       = '0;
    bus.mode            = '0;
    bus.debounce_cycles = '0;
    bus.irq_en          = '1;
    bus.clear           = '0;
    set_mode(0, 2'b01);
    cyc(2);
    check("rst_level", bus.level, 0);
    check("rst_pulse", bus.edge_pulse, 0);
    check("rst_status", bus.status, 0);
    check("rst_irq", bus.irq, 0);
    rst = 1'b1;
    cyc(2);
    bus.signal_in[0] = 1'b1;
    cyc(2);
    check("rise_early", bus.edge_pulse, 0);
    cyc(1);
    check("rise_pulse", bus.edge_pulse, 8'h01);
    check("rise_status", bus.status, 8'h01);
    check("rise_level", bus.level, 8'h01);
    check("rise_irq", bus.irq, 1);
    cyc(1);
    check("rise_one_cycle", bus.edge_pulse, 0);
    check("rise_sticky", bus.status, 8'h01);
    bus.clear = 8'h01;
    cyc(1);
    bus.clear = '0;
    check("clr0_status", bus.status, 0);
    check("clr0_irq", bus.irq, 0);
    set_mode(1, 2'b10);
    set_mode(2, 2'b11);
    p1 = 0;
    p2 = 0;
    bus.signal_in[2:1] = 2'b11;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      p1 += int'(bus.edge_pulse[1]);
      p2 += int'(bus.edge_pulse[2]);
    end
    check("fall_lvl_high", bus.level[2:1], 2'b11);
    bus.signal_in[2:1] = 2'b00;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      p1 += int'(bus.edge_pulse[1]);
      p2 += int'(bus.edge_pulse[2]);
    end
    check("fall_ch1_count", p1, 1);
    check("both_ch2_count", p2, 2);
    check("fall_status", bus.status, 8'h06);
    bus.debounce_cycles = 8'd4;
    set_mode(3, 2'b01);
    p = 0;
    bus.signal_in[3] = 1'b1;
    cyc(3);
    bus.signal_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      p += int'(bus.edge_pulse[3]);
    end
    check("glitch_pulse", p, 0);
    check("glitch_level", bus.level[3], 0);
    bus.signal_in[3] = 1'b1;
    cyc(5);
    check("deb_early", bus.edge_pulse[3], 0);
    cyc(1);
    check("deb_pulse", bus.edge_pulse[3], 1);
    check("deb_level", bus.level[3], 1);
    bus.debounce_cycles = 8'd0;
    bus.clear = '1;
    cyc(1);
    bus.clear = '0;
    check("clr_all", bus.status, 0);
    bus.irq_en = 8'h10;
    set_mode(4, 2'b11);
    bus.signal_in[4] = 1'b1;
    cyc(3);
    check("c4_status", bus.status, 8'h10);
    check("c4_irq", bus.irq, 1);
    cyc(2);
    bus.signal_in[4] = 1'b0;
    cyc(2);
    bus.clear[4] = 1'b1;
    cyc(1);
    bus.clear = '0;
    check("coll_pulse", bus.edge_pulse[4], 1);
    check("coll_status", bus.status[4], 1);
    bus.irq_en = '0;
    #1;
    check("mask_irq", bus.irq, 0);
    check("mask_status", bus.status, 8'h10);
    bus.irq_en = 8'h10;
    #1;
    check("unmask_irq", bus.irq, 1);
    bus.clear[4] = 1'b1;
    cyc(1);
    bus.clear = '0;
    check("w1c_status", bus.status[4], 0);
    check("w1c_irq", bus.irq, 0);
    bus.irq_en = '1;
    p = 0;
    bus.signal_in[5] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      p += int'(bus.edge_pulse[5]);
    end
    check("off_level", bus.level[5], 1);
    check("off_pulse", p, 0);
    check("off_status", bus.status[5], 0);
    set_mode(5, 2'b11);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      p += int'(bus.edge_pulse[5]);
    end
    check("enable_no_pulse", p, 0);
    bus.signal_in[5] = 1'b0;
    cyc(3);
    check("enable_pulse", bus.edge_pulse[5], 1);
    check("enable_status", bus.status[5], 1);
    set_mode(3, 2'b00);
    set_mode(6, 2'b01);
    bus.debounce_cycles = 8'd8;
    bus.signal_in[6] = 1'b1;
    cyc(3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_level", bus.level, 0);
    check("arst_pulse", bus.edge_pulse, 0);
    check("arst_status", bus.status, 0);
    check("arst_irq", bus.irq, 0);
    cyc(2);
    check("arst_hold", bus.status, 0);
    rst = 1'b1;
    cyc(9);
    check("post_rst_early", bus.edge_pulse, 0);
    cyc(1);
    check("post_rst_pulse", bus.edge_pulse, 8'h41);
    check("post_rst_status", bus.status, 8'h41);
    check("post_rst_level", bus.level, 8'h49);
    check("post_rst_irq", bus.irq, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_edge_irq.md
# gpio_edge_irq

Multi-channel successor to the single-bit GPIO edge detector. Each of NUM_CH asynchronous GPIO inputs is synchronised and debounced, then checked against a per-channel mode: disabled, rising, falling or both edges. Matching edges drive a one-cycle pulse and a sticky write-1-to-clear status bit, and the status bits combine into one maskable interrupt. The block sits between the GPIO pads and the peripheral register file.

## Interface
- NUM_CH, 8: number of independent channels (1..32)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEBOUNCE_W, 8: width of the debounce threshold and of each channel counter
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- signal_in  in  NUM_CH  raw asynchronous GPIO inputs
- mode  in  2*NUM_CH  per-channel edge_mode_t, channel i in bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- debounce_cycles  in  DEBOUNCE_W  stability threshold D shared by all channels; 0 = no filtering
- irq_en  in  NUM_CH  per-channel interrupt mask
- clear  in  NUM_CH  write-1-to-clear strobe for status
- level  out  NUM_CH  debounced level
- edge_pulse  out  NUM_CH  one-cycle pulse per qualified edge
- status  out  NUM_CH  sticky edge flags
- irq  out  1  |(status & irq_en)

## Operation
- Reset (rst low, asynchronous): sync chains, level, counters, edge_pulse and status all go to 0, so irq is 0. The outputs stay 0 until the first post-reset clock edge.
- Synchroniser: the last stage of the SYNC_STAGES chain is `synced[i]`.
- Debounce, per channel:
  - If synced == level, the counter is cleared to 0.
  - Otherwise, if D == 0 or cnt ≥ D-1, then level <= synced, cnt <= 0 and an update event fires.
  - Otherwise cnt increments. It saturates at all-ones and never wraps.
  - A mismatch shorter than max(D,1) cycles leaves level unchanged (glitch rejected).
- Edge qualification happens on the same clock edge as the update.
  - Rising: the update sets level 0→1. Falling: the update sets level 1→0.
  - edge_pulse[i] <= update && ((rising && mode[0]) || (falling && mode[1])). It is 0 in every other cycle.
- Debounce and level run regardless of mode. Enabling a channel therefore never produces a spurious edge from stale state.
- Status:
  - status[i] <= (status[i] & ~clear[i]) | edge_pulse_next[i].
  - If set and clear coincide, set wins, so no event is lost.
  - A clear on an already-0 bit has no effect.
- irq is a combinational OR of registered status and irq_en. Changing irq_en takes effect immediately and never alters status.
- Changes to mode or debounce_cycles take effect on the next clock edge.
  - Because the comparison is cnt ≥ D-1, lowering D mid-count may update on the next edge.
- An input held high through reset release is seen as a 0→1 change and reports a rising edge after the normal latency. This is required behaviour.

## Timing
- Let S = SYNC_STAGES, with the input stable before edge E1.
- synced reflects the input after edge E_S.
- level and edge_pulse update after edge E_{S+max(D,1)}, with latency S+max(D,1) cycles.
  - Default S=2, D=0: 3 cycles.
  - S=2, D=4: 6 cycles.
- status is set on the same edge as edge_pulse, and irq follows in the same cycle.
- clear takes effect on the next edge, so status reads 0 one cycle after the strobe.
- The minimum edge spacing that is resolved is max(D,1) cycles per transition.

## Structure
- Package `gpio_edge_pkg`:
  - `edge_mode_t` enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH)
  - MAX_CH = 32 for parameter checks
- Sub-module `gpio_edge_chan`: synchroniser, debounce counter, level flop and qualified edge pulse for one channel. The top level instantiates it NUM_CH times in a generate loop and owns status/irq.
- Elaboration assertions: NUM_CH ≤ MAX_CH, SYNC_STAGES ≥ 2.

## Test plan
- Reset/rise, D=0, mode ch0=RISE: raise signal_in[0] 2 cycles after reset release → edge_pulse[0] high for exactly 1 cycle, 3 cycles after the change. status[0]=1; irq=1 with irq_en[0]=1.
- Falling vs both, D=0: ch1=FALL, ch2=BOTH, drive 0→1→0 with 10 cycles per level → ch1 pulses once (on the fall); ch2 pulses twice.
- Debounce, D=4: a 3-cycle glitch on ch3 → no pulse, level stays 0. Then hold high 6 cycles → pulse 6 cycles after the change.
- Clear collision: status[4]=1, then clear[4] asserted in the same cycle as a new edge on ch4 → status[4] stays 1. Next clear alone → status[4]=0 one cycle later, irq drops.
- Mode off/enable: ch5=OFF, toggle the input → level follows, no pulse or status. Switch to BOTH while the input is steady → no pulse; next toggle pulses.
- Async reset mid-count: D=8, assert rst 3 cycles into a stable-high period → all outputs 0 immediately. Release with input still high → rising edge reported 10 cycles after the first post-reset edge.
